// File: rtl/updown_counter_n.sv
// Modulo-N up/down counter with synchronous clear/load, wrap or saturate at the
// limits, a combinational terminal-count flag, a registered wrap pulse and a sticky ovf flag.
module updown_counter_n #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_nx;
  logic             w_wrap_nx;
  logic             w_ovf_nx;
  logic             w_limit;
  logic             w_lv_ok;
  logic [WIDTH-1:0] w_step;

  // w_limit: the next enabled step in the current direction leaves 0..MODULUS-1
  assign w_limit = up ? (r_count == MAXV) : (r_count == '0);
  assign w_lv_ok = 64'(load_value) < MODULUS;
  assign w_step  = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

  assign tc    = enable & w_limit;
  assign count = r_count;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

  always_comb begin
    w_count_nx = r_count;
    w_wrap_nx  = 1'b0;
    w_ovf_nx   = r_ovf;
    if (clear) begin
      w_count_nx = '0;
      w_ovf_nx   = 1'b0;
    end else if (load) begin
      w_count_nx = w_lv_ok ? load_value : MAXV;
    end else if (enable) begin
      if (w_limit) begin
        w_ovf_nx = 1'b1;
        if (!SATURATE) begin
          w_count_nx = up ? '0 : MAXV;
          w_wrap_nx  = 1'b1;
        end
      end else begin
        w_count_nx = w_step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nx;
      r_wrap  <= w_wrap_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: four configurations share one stimulus stream and are
// compared against an arithmetic reference model, directed scenarios first, then random.
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, up = 1'b0, clear = 1'b0, load = 1'b0;
  logic [3:0] load_value = 4'd0;

  logic [3:0] o_cnt [4];
  logic [1:0] c3;
  logic       o_tc [4], o_wrap [4], o_ovf [4];

  int n_chk = 0, n_fail = 0;
  int m_cnt [4], m_wrap [4], m_ovf [4];
  int MODS [4] = '{10, 10, 16, 2};
  int SATS [4] = '{0, 1, 0, 0};

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .count(o_cnt[0]), .tc(o_tc[0]), .wrap(o_wrap[0]), .ovf(o_ovf[0]));
  updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .count(o_cnt[1]), .tc(o_tc[1]), .wrap(o_wrap[1]), .ovf(o_ovf[1]));
  updown_counter_n #(.WIDTH(4)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(load_value), .count(o_cnt[2]), .tc(o_tc[2]), .wrap(o_wrap[2]), .ovf(o_ovf[2]));
  updown_counter_n #(.WIDTH(2), .MODULUS(2)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(load_value[1:0]), .count(c3), .tc(o_tc[3]), .wrap(o_wrap[3]), .ovf(o_ovf[3]));
  assign o_cnt[3] = {2'b00, c3};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; end
  endtask

  // Reference: take the step in plain integers, then decide what leaving the range means.
  task automatic model_edge(input int i, input bit en, input bit u, input bit cl,
                            input bit ld, input int lv_full);
    int M = MODS[i];
    int lv = (i == 3) ? (lv_full % 4) : lv_full;
    int n;
    m_wrap[i] = 0;
    if (cl) begin
      m_cnt[i] = 0; m_ovf[i] = 0;
    end else if (ld) begin
      m_cnt[i] = (lv < M) ? lv : M - 1;
    end else if (en) begin
      n = m_cnt[i] + (u ? 1 : -1);
      if (n < 0 || n >= M) begin
        m_ovf[i] = 1;
        if (SATS[i] == 0) begin m_cnt[i] = (n + M) % M; m_wrap[i] = 1; end
      end else begin
        m_cnt[i] = n;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i), 32'(o_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("%s_wrap%0d", tag, i), 32'(o_wrap[i]), 32'(m_wrap[i]));
      chk($sformatf("%s_ovf%0d", tag, i), 32'(o_ovf[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic step(input bit rs, input bit en, input bit u, input bit cl,
                      input bit ld, input int lv);
    int etc;
    @(negedge clk);
    reset = rs; enable = en; up = u; clear = cl; load = ld; load_value = 4'(lv);
    if (rs) model_zero();
    #1;
    for (int i = 0; i < 4; i++) begin
      etc = (en && (u ? (m_cnt[i] == MODS[i] - 1) : (m_cnt[i] == 0))) ? 1 : 0;
      chk($sformatf("tc%0d", i), 32'(o_tc[i]), 32'(etc));
    end
    @(posedge clk);
    if (!rs) for (int i = 0; i < 4; i++) model_edge(i, en, u, cl, ld, lv);
    #1;
    check_all("edge");
  endtask

  int seq32 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int seq33 [11] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
  bit r_en, r_up;

  initial begin
    model_zero();
    #1;
    check_all("reset");
    // count up 12 edges from reset
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 1, 0, 0, 0);
      chk("r32_cnt", 32'(o_cnt[0]), 32'(seq32[k]));
      chk("r32_wrap", 32'(o_wrap[0]), (k == 9) ? 32'd1 : 32'd0);
      chk("r32_ovf", 32'(o_ovf[0]), (k >= 9) ? 32'd1 : 32'd0);
    end
    // out-of-range load clamps, then count down through 0
    step(0, 0, 0, 0, 1, 13);
    chk("r33_load", 32'(o_cnt[0]), 32'd9);
    for (int k = 0; k < 11; k++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("r33_cnt", 32'(o_cnt[0]), 32'(seq33[k]));
    end
    // saturating instance holds at 9
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1, 8);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 0, 0, 0);
      chk("r34_cnt", 32'(o_cnt[1]), 32'd9);
      chk("r34_wrap", 32'(o_wrap[1]), 32'd0);
      chk("r34_ovf", 32'(o_ovf[1]), (k >= 1) ? 32'd1 : 32'd0);
    end
    // clear beats load and enable; load beats enable
    step(0, 0, 1, 0, 1, 5);
    step(0, 1, 1, 1, 1, 7);
    chk("r35_clr", 32'(o_cnt[0]), 32'd0);
    chk("r35_ovf", 32'(o_ovf[1]), 32'd0);
    step(0, 1, 1, 0, 1, 3);
    chk("r35_ld", 32'(o_cnt[0]), 32'd3);
    // async reset in the middle of the wrap pulse
    step(0, 0, 1, 0, 1, 9);
    step(0, 1, 1, 0, 0, 0);
    chk("r36_pulse", 32'(o_wrap[0]), 32'd1);
    #2 reset = 1'b1;
    model_zero();
    #1;
    check_all("r36_async");
    step(0, 1, 1, 0, 0, 0);
    chk("r36_c1", 32'(o_cnt[0]), 32'd1);
    step(0, 1, 1, 0, 0, 0);
    chk("r36_c2", 32'(o_cnt[0]), 32'd2);
    // full-range binary roll-over, then hold with enable low
    step(0, 0, 1, 0, 1, 15);
    step(0, 1, 1, 0, 0, 0);
    chk("r37_cnt", 32'(o_cnt[2]), 32'd0);
    chk("r37_wrap", 32'(o_wrap[2]), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1, 0, 0, 0);
      chk("r37_hold", 32'(o_cnt[2]), 32'd0);
      chk("r37_nowrap", 32'(o_wrap[2]), 32'd0);
    end
    // random traffic; direction changes rarely so the limits get reached
    r_up = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) r_up = ~r_up;
      r_en = ($urandom_range(9) < 8);
      step(($urandom_range(99) == 0), r_en, r_up, ($urandom_range(29) == 0),
           ($urandom_range(11) == 0), int'($urandom_range(15)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width in bits (legal range 2..32).
REQ-002 Parameter MODULUS, default 2**WIDTH, SHALL set the count range 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 Parameter SATURATE, default 0, SHALL select the limit mode: 0 = wrap, 1 = hold at limit.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 enable  input  1  SHALL permit counting when high.
REQ-007 up  input  1  SHALL set direction: 1 = increment, 0 = decrement.
REQ-008 clear  input  1  SHALL be a synchronous clear to 0.
REQ-009 load  input  1  SHALL be a synchronous load strobe.
REQ-010 load_value  input  WIDTH  SHALL be the value applied on load.
REQ-011 count  output  WIDTH  SHALL be the registered count value.
REQ-012 tc  output  1  SHALL be the combinational terminal-count flag.
REQ-013 wrap  output  1  SHALL be a registered one-cycle wrap pulse.
REQ-014 ovf  output  1  SHALL be a registered sticky overflow/underflow flag.

Function
REQ-015 Per rising clk edge, the priority SHALL be clear > load > enable-count > hold.
REQ-016 clear=1 SHALL set count=0 and ovf=0, whatever the load and enable values.
REQ-017 load=1 (clear=0) SHALL set count=load_value if load_value<MODULUS, else count=MODULUS-1; ovf and wrap SHALL be unaffected.
REQ-018 enable=1, up=1, count<MODULUS-1 SHALL give count+1; with up=0 and count>0 SHALL give count-1.
REQ-019 With SATURATE=0, up at MODULUS-1 SHALL give 0, and down at 0 SHALL give MODULUS-1.
REQ-020 With SATURATE=1, count SHALL hold at MODULUS-1 (up) or at 0 (down).
REQ-021 Any enabled step at the limit (REQ-019/020 cases) SHALL set ovf=1 on the same edge; ovf SHALL stay set until clear or reset.
REQ-022 wrap SHALL be high for exactly the cycle after an edge where the count wrapped (SATURATE=0 only); with SATURATE=1, wrap SHALL stay 0.
REQ-023 Consecutive wrapping edges (e.g. MODULUS=2, up) SHALL hold wrap high continuously, one pulse per wrap.
REQ-024 Defined per cycle: tc = enable & ((up & count==MODULUS-1) | (~up & count==0)); tc SHALL have no other dependencies.
REQ-025 A direction change SHALL take effect on the next enabled edge with no lost or extra step.
REQ-026 enable=0 with clear=0 and load=0 SHALL hold count and ovf, and SHALL drive wrap=0 after the edge.
REQ-027 Count arithmetic SHALL be WIDTH bits; with MODULUS=2**WIDTH, natural binary roll-over SHALL match REQ-019.

Reset
REQ-028 reset=1 SHALL immediately, independent of clk, force count=0, wrap=0 and ovf=0.
REQ-029 While reset=1, all synchronous inputs SHALL be ignored.
REQ-030 After reset deasserts, the first state change SHALL occur on the next rising clk edge per REQ-015.
REQ-031 Reset asserted mid-count or mid-wrap-pulse SHALL abort the pulse and clear all state with no residual effect.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-032 Reset, then enable=1, up=1 for 12 edges -> count 1..9,0,1,2; wrap high for the one cycle after the 9->0 edge; ovf=1 from that edge.
REQ-033 load=1, load_value=13 -> count=9; then up=0 for 11 edges -> 8..0,9,8; tc=1 while count=0 and up=0.
REQ-034 SATURATE=1: load 8, enable up for 4 edges -> 9,9,9,9; wrap never 1; ovf=1 after the second edge.
REQ-035 Same edge clear=1, load=1, enable=1 at count=5 -> count=0, ovf=0; a later load=1 with enable=1, load_value=3 -> count=3 (no increment).
REQ-036 Assert reset asynchronously between edges during the wrap pulse at count=0 -> count, wrap and ovf go 0 before the next edge; counting resumes 1,2 after release.
REQ-037 WIDTH=4, MODULUS=16 default: count up from 15 -> 0 with wrap pulse; enable toggled off 2 cycles -> count holds and wrap=0.
